// File: rtl/ymat_row_writer.sv
// rtl/ymat_row_writer.sv - Y-matrix single-entry read-modify-write updater
// Applies (row, col, value) updates to 256-bit SRAM words holding 16 x 16-bit entries.
module ymat_row_writer #(
    parameter int NUM_ROWS = 16,
    parameter int NUM_COLS = 256,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chg_valid,
    output logic              chg_ready,
    input  logic [10:0]       chg_row,
    input  logic [10:0]       chg_col,
    input  logic              chg_op,
    input  logic [15:0]       chg_value,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_re,
    output logic              sram_we,
    output logic [255:0]      sram_wdata,
    input  logic [255:0]      sram_rdata,
    output logic              chg_done,
    output logic              chg_err,
    output logic [15:0]       chg_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;

    localparam int WPR = NUM_COLS / 16;
    localparam int CW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(READ_LAT - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_slot;
    logic              r_op;
    logic [15:0]       r_value;
    logic [255:0]      r_wdata;
    logic [CW-1:0]     r_wait;
    logic [15:0]       r_count;

    logic              w_oob;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_old;
    logic [255:0]      w_merged;

    assign w_oob  = (32'(chg_row) >= 32'(NUM_ROWS)) || (32'(chg_col) >= 32'(NUM_COLS));
    assign w_addr = ADDR_W'(32'(chg_row) * 32'(WPR) + 32'(chg_col[10:4]));

    // Only the addressed slot changes; the other 15 entries pass through.
    always_comb begin
        w_old    = sram_rdata[{r_slot, 4'b0000} +: 16];
        w_merged = sram_rdata;
        w_merged[{r_slot, 4'b0000} +: 16] = r_op ? (w_old + r_value) : r_value;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_slot  <= '0;
            r_op    <= 1'b0;
            r_value <= '0;
            r_wdata <= '0;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (chg_valid) begin
                        r_slot  <= chg_col[3:0];
                        r_op    <= chg_op;
                        r_value <= chg_value;
                        if (w_oob) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_addr  <= w_addr;
                            r_state <= S_RD;
                        end
                    end
                end
                S_CHECK: r_state <= S_IDLE;
                S_RD: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == LAST_WAIT) begin
                        r_wdata <= w_merged;
                        r_state <= S_WR;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WR: begin
                    r_count <= r_count + 16'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign chg_ready  = (r_state == S_IDLE);
    assign chg_err    = (r_state == S_CHECK);
    assign sram_re    = (r_state == S_RD);
    assign sram_we    = (r_state == S_WR);
    assign chg_done   = (r_state == S_WR);
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign chg_count  = r_count;

endmodule

// File: tb/tb_ymat_row_writer.sv
// tb/tb_ymat_row_writer.sv - scoreboard bench for ymat_row_writer (READ_LAT 1 and 2)
module tb_ymat_row_writer;

    typedef struct {
        logic [7:0]   addr;
        logic [255:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [10:0]  chg_row = '0, chg_col = '0;
    logic         chg_op = 1'b0;
    logic [15:0]  chg_value = '0;

    logic         rdy0, re0, we0, done0, err0;
    logic [7:0]   addr0;
    logic [255:0] wdata0, rdata0;
    logic [15:0]  cnt0;
    logic         rdy1, re1, we1, done1, err1;
    logic [7:0]   addr1;
    logic [255:0] wdata1, rdata1, p1;
    logic [15:0]  cnt1;

    logic [255:0] mem0 [256];
    logic [255:0] mem1 [256];
    logic         ld_en = 1'b0;
    logic [7:0]   ld_addr = '0;
    logic [255:0] ld_data = '0;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   re_cnt0 = 0;
    int   exp_cnt0 = 0;

    ymat_row_writer #(.NUM_ROWS(16), .NUM_COLS(256), .ADDR_W(8), .READ_LAT(1)) u0 (
        .clock(clk), .reset(reset), .chg_valid(v0), .chg_ready(rdy0),
        .chg_row(chg_row), .chg_col(chg_col), .chg_op(chg_op), .chg_value(chg_value),
        .sram_addr(addr0), .sram_re(re0), .sram_we(we0), .sram_wdata(wdata0),
        .sram_rdata(rdata0), .chg_done(done0), .chg_err(err0), .chg_count(cnt0)
    );

    ymat_row_writer #(.NUM_ROWS(16), .NUM_COLS(256), .ADDR_W(8), .READ_LAT(2)) u1 (
        .clock(clk), .reset(reset), .chg_valid(v1), .chg_ready(rdy1),
        .chg_row(chg_row), .chg_col(chg_col), .chg_op(chg_op), .chg_value(chg_value),
        .sram_addr(addr1), .sram_re(re1), .sram_we(we1), .sram_wdata(wdata1),
        .sram_rdata(rdata1), .chg_done(done1), .chg_err(err1), .chg_count(cnt1)
    );

    // SRAM models: latency 1 for u0, latency 2 for u1
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re0) rdata0 <= mem0[addr0];
        p1     <= mem1[addr1];
        rdata1 <= p1;
        if (ld_en) begin
            mem0[ld_addr] <= ld_data;
            mem1[ld_addr] <= ld_data;
        end else begin
            if (we0) mem0[addr0] <= wdata0;
            if (we1) mem1[addr1] <= wdata1;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] merge(input logic [255:0] w, input logic [3:0] slot,
                                           input logic op, input logic [15:0] val);
        logic [255:0] m;
        m = w;
        if (op) m[slot*16 +: 16] = w[slot*16 +: 16] + val;
        else    m[slot*16 +: 16] = val;
        return m;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (re0 || we0) check("u0_re_we_excl", {255'd0, re0 & we0}, 256'd0);
        if (re1 || we1) check("u1_re_we_excl", {255'd0, re1 & we1}, 256'd0);
        if (re0) re_cnt0++;
        if (we0) begin
            check("u0_sb_nonempty", {255'd0, sb0.size() != 0}, 256'd1);
            if (sb0.size() != 0) begin
                e = sb0.pop_front();
                check("u0_sb_addr", {248'd0, addr0}, {248'd0, e.addr});
                check("u0_sb_wdata", wdata0, e.data);
            end
        end
        if (we1) begin
            check("u1_sb_nonempty", {255'd0, sb1.size() != 0}, 256'd1);
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                check("u1_sb_addr", {248'd0, addr1}, {248'd0, e.addr});
                check("u1_sb_wdata", wdata1, e.data);
            end
        end
    end

    task automatic load(input logic [7:0] a, input logic [255:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic push0(input logic [10:0] row, input logic [10:0] col, input logic op,
                         input logic [15:0] val);
        exp_t e;
        e.addr = 8'(row * 16 + 11'(col[10:4]));
        e.data = merge(mem0[e.addr], col[3:0], op, val);
        sb0.push_back(e);
    endtask

    task automatic drive(input logic [10:0] row, input logic [10:0] col, input logic op,
                         input logic [15:0] val);
        chg_row = row; chg_col = col; chg_op = op; chg_value = val;
    endtask

    task automatic wait_we0(output int t);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (we0) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("u0_we_timeout", {255'd0, we0}, 256'd1);
    endtask

    initial begin
        int t_a, t_b, re_before;
        logic [255:0] exp_w, pat;

        for (int i = 0; i < 256; i++) load(8'(i), {8{$urandom}});
        @(negedge clk);
        check("rst_ready", {255'd0, rdy0}, 256'd1);
        check("rst_re_we", {254'd0, re0, we0}, 256'd0);
        check("rst_addr", {248'd0, addr0}, 256'd0);
        check("rst_wdata", wdata0, 256'd0);
        check("rst_done_err", {254'd0, done0, err0}, 256'd0);
        check("rst_count", {240'd0, cnt0}, 256'd0);
        reset = 1'b0;

        // overwrite with exact cycle timing
        load(8'h22, 256'd0);
        @(negedge clk);
        push0(11'd2, 11'd37, 1'b0, 16'hBEEF);
        drive(11'd2, 11'd37, 1'b0, 16'hBEEF); v0 = 1'b1;
        @(posedge clk); #1 v0 = 1'b0;
        @(negedge clk);
        check("t1_c1_re", {255'd0, re0}, 256'd1);
        check("t1_c1_addr", {248'd0, addr0}, 256'h22);
        @(negedge clk);
        check("t1_c2_idle_bus", {254'd0, re0, we0}, 256'd0);
        @(negedge clk);
        exp_w = 256'hBEEF << 80;
        check("t1_c3_we_done", {254'd0, we0, done0}, 256'd3);
        check("t1_c3_wdata", wdata0, exp_w);
        exp_cnt0++;
        @(negedge clk);
        check("t1_c4_ready", {255'd0, rdy0}, 256'd1);
        check("t1_count", {240'd0, cnt0}, 256'(exp_cnt0));

        // add with 16-bit wrap
        load(8'h00, {256{1'b1}});
        @(negedge clk);
        push0(11'd0, 11'd0, 1'b1, 16'h0001);
        drive(11'd0, 11'd0, 1'b1, 16'h0001); v0 = 1'b1;
        @(posedge clk); #1 v0 = 1'b0;
        wait_we0(t_a);
        exp_w = {{240{1'b1}}, 16'h0000};
        check("t2_wrap_wdata", wdata0, exp_w);
        exp_cnt0++;

        // out-of-range row and col
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            re_before = re_cnt0;
            if (k == 0) drive(11'd16, 11'd0, 1'b0, 16'h5555);
            else        drive(11'd3, 11'd256, 1'b0, 16'h5555);
            v0 = 1'b1;
            @(posedge clk); #1 v0 = 1'b0;
            @(negedge clk);
            check("t3_c1_err", {255'd0, err0}, 256'd1);
            check("t3_c1_ready", {255'd0, rdy0}, 256'd0);
            @(negedge clk);
            check("t3_c2_ready", {255'd0, rdy0}, 256'd1);
            check("t3_c2_err", {255'd0, err0}, 256'd0);
            repeat (4) @(negedge clk);
            check("t3_no_re", 256'(re_cnt0), 256'(re_before));
            check("t3_count", {240'd0, cnt0}, 256'(exp_cnt0));
        end

        // valid held through two back-to-back requests
        push0(11'd5, 11'd17, 1'b0, 16'hA5A5);
        push0(11'd7, 11'd200, 1'b1, 16'h1357);
        drive(11'd5, 11'd17, 1'b0, 16'hA5A5); v0 = 1'b1;
        @(posedge clk); #1 drive(11'd7, 11'd200, 1'b1, 16'h1357);
        wait_we0(t_a);
        @(negedge clk);
        check("t4_c4_ready", {255'd0, rdy0}, 256'd1);
        @(posedge clk); #1 v0 = 1'b0;
        wait_we0(t_b);
        check("t4_write_gap", 256'(t_b - t_a), 256'd4);
        exp_cnt0 += 2;
        @(negedge clk);
        check("t4_count", {240'd0, cnt0}, 256'(exp_cnt0));

        // reset during WAIT aborts the write
        drive(11'd9, 11'd99, 1'b0, 16'hDEAD); v0 = 1'b1;
        @(posedge clk); #1 v0 = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_cnt0 = 0;
        @(negedge clk);
        check("t5_ready", {255'd0, rdy0}, 256'd1);
        check("t5_re_we", {254'd0, re0, we0}, 256'd0);
        check("t5_addr", {248'd0, addr0}, 256'd0);
        check("t5_wdata", wdata0, 256'd0);
        check("t5_done_err", {254'd0, done0, err0}, 256'd0);
        check("t5_count", {240'd0, cnt0}, 256'd0);
        repeat (4) @(negedge clk);

        // random in-range updates through the scoreboard
        for (int n = 0; n < 16; n++) begin
            logic [10:0] r, c;
            logic        o;
            logic [15:0] v;
            r = 11'($urandom_range(0, 15));
            c = 11'($urandom_range(0, 255));
            o = 1'($urandom_range(0, 1));
            v = 16'($urandom);
            push0(r, c, o, v);
            drive(r, c, o, v); v0 = 1'b1;
            @(posedge clk); #1 v0 = 1'b0;
            wait_we0(t_a);
            exp_cnt0++;
            @(negedge clk);
        end
        check("rand_count", {240'd0, cnt0}, 256'(exp_cnt0));

        // READ_LAT=2 instance
        pat = {8{$urandom}};
        load(8'h1F, pat);
        @(negedge clk);
        begin
            exp_t e;
            e.addr = 8'h1F;
            e.data = {16'h1234, pat[239:0]};
            sb1.push_back(e);
        end
        drive(11'd1, 11'd255, 1'b0, 16'h1234); v1 = 1'b1;
        @(posedge clk); #1 v1 = 1'b0;
        @(negedge clk);
        check("t6_c1_re", {255'd0, re1}, 256'd1);
        check("t6_c1_addr", {248'd0, addr1}, 256'h1F);
        @(negedge clk);
        check("t6_c2_bus", {254'd0, re1, we1}, 256'd0);
        @(negedge clk);
        check("t6_c3_bus", {254'd0, re1, we1}, 256'd0);
        @(negedge clk);
        check("t6_c4_we", {255'd0, we1}, 256'd1);
        check("t6_c4_top", {240'd0, wdata1[255:240]}, 256'h1234);
        @(negedge clk);
        check("t6_count", {240'd0, cnt1}, 256'd1);

        repeat (3) @(negedge clk);
        check("sb0_drained", 256'(sb0.size()), 256'd0);
        check("sb1_drained", 256'(sb1.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
